// File: rtl/maxpool_backward.sv
// Backward pass of a 2x2 / stride-2 max-pool: recomputes each window's argmax from the
// forward feature map and routes the pooled gradient there, zeroing the other three cells.
module maxpool_backward #(
    parameter int FM_WIDTH  = 62,
    parameter int FM_HEIGHT = 62
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] featureMap  [0:FM_WIDTH-1][0:FM_HEIGHT-1],
    input  logic signed [15:0] grad_pooled [0:FM_WIDTH/2-1][0:FM_HEIGHT/2-1],
    output logic signed [15:0] grad_fm     [0:FM_WIDTH-1][0:FM_HEIGHT-1],
    output logic               busy,
    output logic               done
);

    localparam int PW = FM_WIDTH / 2;
    localparam int PH = FM_HEIGHT / 2;
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;
    localparam int JW = (PH > 1) ? $clog2(PH) : 1;
    localparam int XW = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
    localparam int YW = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(PW - 1);
    localparam logic [JW-1:0] J_LAST = JW'(PH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state;
    logic [IW-1:0]      i;
    logic [JW-1:0]      j;
    logic [XW-1:0]      x0, x1;
    logic [YW-1:0]      y0, y1;
    logic signed [15:0] best;
    logic signed [15:0] g;
    logic [1:0]         sel;
    logic               last_win;

    // Argmax over the current window; strict '>' keeps the earliest candidate on ties.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        x0   = XW'({i, 1'b0});
        x1   = x0 | XW'(1);
        y0   = YW'({j, 1'b0});
        y1   = y0 | YW'(1);
        g    = grad_pooled[i][j];
        best = featureMap[x0][y0];
        sel  = 2'd0;
        if (featureMap[x0][y1] > best) begin
            best = featureMap[x0][y1];
            sel  = 2'd1;
        end
        if (featureMap[x1][y0] > best) begin
            best = featureMap[x1][y0];
            sel  = 2'd2;
        end
        if (featureMap[x1][y1] > best) begin
            best = featureMap[x1][y1];
            sel  = 2'd3;
        end
    end

    assign last_win = (i == I_LAST) && (j == J_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            i     <= '0;
            j     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    i <= '0;
                    j <= '0;
                    if (PW == 0 || PH == 0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (last_win) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (j == J_LAST) begin
                        j <= '0;
                        i <= i + IW'(1);
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Each output cell owns a flop that only listens to its own window and position.
    for (genvar x = 0; x < FM_WIDTH; x++) begin : g_row
        for (genvar y = 0; y < FM_HEIGHT; y++) begin : g_col
            logic signed [15:0] q;
            if (x < 2 * PW && y < 2 * PH) begin : g_win
                localparam logic [IW-1:0] WI  = IW'(x / 2);
                localparam logic [JW-1:0] WJ  = JW'(y / 2);
                localparam logic [1:0]    POS = 2'((x % 2) * 2 + (y % 2));
                // NOTE: this storage is a register array, not RAM, so it takes the async reset.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        q <= '0;
                    end else if (state == S_CLEAR) begin
                        q <= '0;
                    end else if (state == S_SCAN && i == WI && j == WJ) begin
                        q <= (sel == POS) ? g : 16'sd0;
                    end
                end
            end else begin : g_pad
                // Trailing row/column of an odd dimension is never covered by a window.
                assign q = '0;
            end
            assign grad_fm[x][y] = q;
        end
    end

endmodule

// File: tb/tb_maxpool_backward.sv
// Directed self-checking bench for maxpool_backward using 4x4, 2x2 and 5x5 instances
// that share clock and reset.
module tb_maxpool_backward;

    logic clk = 1'b0;
    logic rst;
    logic start4, start2, start5;
    logic busy4, done4, busy2, done2, busy5, done5;

    logic signed [15:0] fm4 [0:3][0:3];
    logic signed [15:0] gp4 [0:1][0:1];
    logic signed [15:0] g4  [0:3][0:3];
    logic signed [15:0] fm2 [0:1][0:1];
    logic signed [15:0] gp2 [0:0][0:0];
    logic signed [15:0] g2  [0:1][0:1];
    logic signed [15:0] fm5 [0:4][0:4];
    logic signed [15:0] gp5 [0:1][0:1];
    logic signed [15:0] g5  [0:4][0:4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxpool_backward #(.FM_WIDTH(4), .FM_HEIGHT(4)) u_fm4 (
        .clk(clk), .rst(rst), .start(start4), .featureMap(fm4),
        .grad_pooled(gp4), .grad_fm(g4), .busy(busy4), .done(done4)
    );

    maxpool_backward #(.FM_WIDTH(2), .FM_HEIGHT(2)) u_fm2 (
        .clk(clk), .rst(rst), .start(start2), .featureMap(fm2),
        .grad_pooled(gp2), .grad_fm(g2), .busy(busy2), .done(done2)
    );

    maxpool_backward #(.FM_WIDTH(5), .FM_HEIGHT(5)) u_fm5 (
        .clk(clk), .rst(rst), .start(start5), .featureMap(fm5),
        .grad_pooled(gp5), .grad_fm(g5), .busy(busy5), .done(done5)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Monotonic 4x4 map: the max of every window sits at its odd/odd corner.
    task automatic check_g4(input string tag, input logic [15:0] val);
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                check($sformatf("%s g[%0d][%0d]", tag, x, y), g4[x][y],
                      (x % 2 == 1 && y % 2 == 1) ? val : 16'h0000);
    endtask

    // Accepts a start on the 4x4 instance and checks busy/done per cycle.
    task automatic run4(input string tag, input int glitch_k, input int rst_k);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == rst_k) begin
                rst = 1'b0;
                #1;
                check_bit({tag, " busy at reset"}, busy4, 1'b0);
                check_bit({tag, " done at reset"}, done4, 1'b0);
                check_g4({tag, " reset"}, 16'h0000);
                return;
            end
            check_bit($sformatf("%s busy k%0d", tag, k), busy4, k <= 5);
            check_bit($sformatf("%s done k%0d", tag, k), done4, k == 6);
            start4 = (k == glitch_k);
            if (k < 6) @(negedge clk);
        end
        start4 = 1'b0;
    endtask

    // Accepts a start on the 2x2 (which=2) or 5x5 (which=5) instance.
    task automatic run_small(input string tag, input int which, input int done_k);
        @(negedge clk);
        if (which == 2) start2 = 1'b1; else start5 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start5 = 1'b0;
        for (int k = 1; k <= done_k; k++) begin
            check_bit($sformatf("%s busy k%0d", tag, k), (which == 2) ? busy2 : busy5, k < done_k);
            check_bit($sformatf("%s done k%0d", tag, k), (which == 2) ? done2 : done5, k == done_k);
            if (k < done_k) @(negedge clk);
        end
    endtask

    initial begin
        int extra;
        rst    = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        start5 = 1'b0;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) fm4[x][y] = 16'(x * 4 + y);
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++) begin
                gp4[x][y] = 16'h0010;
                fm2[x][y] = 16'h0005;
                gp5[x][y] = 16'h0003;
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) fm5[x][y] = 16'h0001;
        gp2[0][0] = 16'hFFF0;

        // Reset state
        #1;
        check_bit("reset busy", busy4, 1'b0);
        check_bit("reset done", done4, 1'b0);
        check_g4("reset", 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Scenario 1: monotonic 4x4 map
        run4("s1", 0, 0);
        check_g4("s1", 16'h0010);

        // Scenario 5: start during SCAN ignored, then rerun overwrites
        run4("s5a", 3, 0);
        check_g4("s5a", 16'h0010);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) extra++;
        end
        check("s5 no queued done", 16'(extra), 16'h0000);
        check_bit("s5 idle busy", busy4, 1'b0);
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++) gp4[x][y] = 16'h0020;
        run4("s5b", 0, 0);
        check_g4("s5b", 16'h0020);

        // Scenario 6: reset mid-scan, then a clean rerun
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++) gp4[x][y] = 16'h0010;
        run4("s6", 0, 4);
        repeat (3) begin
            @(negedge clk);
            check_bit("s6 no done in reset", done4, 1'b0);
        end
        rst = 1'b1;
        run4("s6b", 0, 0);
        check_g4("s6b", 16'h0010);

        // Scenario 2: all-equal window, tie goes to the first candidate
        run_small("s2", 2, 3);
        check("s2 g[0][0]", g2[0][0], 16'hFFF0);
        check("s2 g[0][1]", g2[0][1], 16'h0000);
        check("s2 g[1][0]", g2[1][0], 16'h0000);
        check("s2 g[1][1]", g2[1][1], 16'h0000);

        // Scenario 3: signed compare, 0x7FFF beats 0x8000/0xFFFF/0x0000
        fm2[0][0] = 16'h8000;
        fm2[0][1] = 16'h7FFF;
        fm2[1][0] = 16'hFFFF;
        fm2[1][1] = 16'h0000;
        gp2[0][0] = 16'h1234;
        run_small("s3", 2, 3);
        check("s3 g[0][0]", g2[0][0], 16'h0000);
        check("s3 g[0][1]", g2[0][1], 16'h1234);
        check("s3 g[1][0]", g2[1][0], 16'h0000);
        check("s3 g[1][1]", g2[1][1], 16'h0000);

        // Scenario 4: odd 5x5 map, trailing row/column stay zero
        run_small("s4", 5, 6);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                check($sformatf("s4 g[%0d][%0d]", x, y), g5[x][y],
                      (x % 2 == 0 && y % 2 == 0 && x < 4 && y < 4) ? 16'h0003 : 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
